seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_hex_dec.sv | 33 +++
 rtl/seg_scan_ctrl_hex_dec.sv | 14 +
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan controller.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  // Segment patterns, a..g on bits 0..6, active-high
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_hex_dec.sv
// Hex nibble to seven-segment pattern (a..g on bits 0..6), purely combinational.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  // Table lookup of the segment pattern for one nibble
  always_comb begin
    seg_c = SEG_OFF;
    case (hex)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl_hex_dec.sv
// Thin wrapper around seg_hex_dec exposing the decoder under the controller's name.
module seg_scan_ctrl_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  seg_hex_dec u_dec (
    .hex   (hex),
    .seg_c (seg_c)
  );

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: synchronizes the slow scan clock,
// blanks between digits, and drives one digit at a time from a per-frame
// snapshot of the display data.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   seg_com,
  output logic [7:0]              seg_data,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DAT_W = 4 * NUM_DIGITS;

  logic                  sync1, sync2, sync3;
  logic                  scan_tick_c;
  scan_state_e           state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DAT_W-1:0]      snap_digits, snap_digits_nx;
  logic [NUM_DIGITS-1:0] snap_dp, snap_dp_nx;
  logic [NUM_DIGITS-1:0] seg_com_nx;
  logic [7:0]            seg_data_nx;
  logic                  frame_start_nx;
  logic [3:0]            cur_hex_c;
  logic [6:0]            cur_seg_c;
  logic                  lz_blank_c;
  logic                  last_idx_c;

  // Two-flop synchronizer plus edge-history flop for the scan clock level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= scan_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign scan_tick_c = sync2 & ~sync3;
  assign last_idx_c  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign cur_hex_c   = snap_digits[{idx, 2'b00} +: 4];

  seg_hex_dec u_hex_dec (
    .hex   (cur_hex_c),
    .seg_c (cur_seg_c)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask_c;

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lz_mask_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (snap_digits[4*i +: 4] == 4'h0);
      lz_mask_c[i] = all_zero & (i != 0);
    end
  end

  assign lz_blank_c = lz_mask_c[idx];
`else
  assign lz_blank_c = 1'b0;
`endif

  // Next-state and next-output logic for the scan sequencer
  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    cnt_nx         = cnt;
    snap_digits_nx = snap_digits;
    snap_dp_nx     = snap_dp;
    seg_com_nx     = seg_com;
    seg_data_nx    = seg_data;
    frame_start_nx = 1'b0;
    case (state)
      IDLE, DRIVE: begin
        if (scan_tick_c) begin
          state_nx    = BLANK;
          idx_nx      = last_idx_c ? '0 : idx + IDX_W'(1);
          cnt_nx      = CNT_W'(BLANK_CYCLES - 1);
          seg_com_nx  = '1;
          seg_data_nx = 8'h00;
          if (last_idx_c) begin
            snap_digits_nx = digits;
            snap_dp_nx     = dp;
            frame_start_nx = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt == CNT_W'(0)) begin
          state_nx    = DRIVE;
          seg_com_nx  = ~(NUM_DIGITS'(1) << idx);
          seg_data_nx = {snap_dp[idx], lz_blank_c ? SEG_OFF : cur_seg_c};
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state, snapshot and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= IDX_W'(NUM_DIGITS - 1);
      cnt         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      seg_com     <= '1;
      seg_data    <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      snap_digits <= snap_digits_nx;
      snap_dp     <= snap_dp_nx;
      seg_com     <= seg_com_nx;
      seg_data    <= seg_data_nx;
      frame_start <= frame_start_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: each scan_clk rise pushes the expected
// digit select / segment byte; the monitor pops on every new digit drive.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scan_clk = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0] dp = '0;
  logic [ND-1:0] seg_com;
  logic [7:0]    seg_data;
  logic          frame_start;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .BLANK_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_clk    (scan_clk),
    .digits      (digits),
    .dp          (dp),
    .seg_com     (seg_com),
    .seg_data    (seg_data),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] com;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_idx    = ND - 1;
  logic [31:0] m_snap   = '0;
  logic [7:0]  m_dp     = '0;
  int          fs_cnt   = 0;
  logic [7:0]  prev_com = 8'hFF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int i);
    logic [6:0] s;
    s = hex7(4'(m_snap >> (4 * i)));
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      logic blank;
      blank = (i != 0);
      for (int j = i; j < int'(ND); j++)
        if (4'(m_snap >> (4 * j)) != 4'h0) blank = 1'b0;
      if (blank) s = 7'h00;
    end
`endif
    return {m_dp[i], s};
  endfunction

  // Model one accepted scan tick and queue what the next drive must show
  task automatic push_tick();
    exp_t e;
    m_idx = (m_idx + 1) % int'(ND);
    if (m_idx == 0) begin
      m_snap = digits;
      m_dp   = dp;
    end
    e.idx  = m_idx;
    e.com  = ~(8'h01 << m_idx);
    e.data = exp_seg(m_idx);
    exp_q.push_back(e);
  endtask

  // Monitor: a drive is seg_com leaving all-ones
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_com = 8'hFF;
    end else begin
      if (frame_start) fs_cnt++;
      if (prev_com == 8'hFF && seg_com != 8'hFF) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_drive", seg_com, 8'hFF);
        end else begin
          e = exp_q.pop_front();
          check_eq($sformatf("com_d%0d", e.idx), seg_com, e.com);
          check_eq($sformatf("data_d%0d", e.idx), seg_data, e.data);
          check_eq($sformatf("frame_d%0d", e.idx), fs_cnt, (e.idx == 0) ? 1 : 0);
          fs_cnt = 0;
        end
      end
      prev_com = seg_com;
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    push_tick();
    scan_clk = 1'b1;
    repeat (3) @(negedge clk);
    scan_clk = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_idx = ND - 1;
    exp_q.delete();
    fs_cnt = 0;
  endtask

  // Single tick from a driven digit with edge-by-edge latency checks
  task automatic latency_tick();
    logic [7:0] old_com, new_com;
    @(negedge clk);
    old_com = seg_com;
    push_tick();
    new_com = exp_q[$].com;
    scan_clk = 1'b1;
    @(negedge clk);
    @(negedge clk); check_eq("lat_e2_hold", seg_com, old_com);
    @(negedge clk); check_eq("lat_e3_blank", seg_com, 8'hFF);
    scan_clk = 1'b0;
    @(negedge clk); check_eq("lat_e4_data0", seg_data, 8'h00);
    repeat (2) @(negedge clk); check_eq("lat_e6_blank", seg_com, 8'hFF);
    @(negedge clk); check_eq("lat_e7_drive", seg_com, new_com);
    repeat (2) @(negedge clk);
  endtask

  // Second synchronized rise lands inside blanking and must be ignored
  task automatic double_rise();
    logic [7:0] new_com;
    @(negedge clk);
    push_tick();
    new_com = exp_q[$].com;
    scan_clk = 1'b1;
    @(negedge clk);
    @(negedge clk); scan_clk = 1'b0;
    @(negedge clk); scan_clk = 1'b1;
    repeat (3) @(negedge clk); check_eq("dbl_e6_blank", seg_com, 8'hFF);
    @(negedge clk); check_eq("dbl_e7_drive", seg_com, new_com);
    scan_clk = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("dbl_no_extra", seg_com, new_com);
    check_eq("dbl_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_com", seg_com, 8'hFF);
    check_eq("rst_data", seg_data, 8'h00);
    check_eq("rst_frame", frame_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full frame of 0x12345678
    digits = 32'h12345678;
    dp     = 8'h00;
    for (int i = 0; i < 8; i++) tick();

    // Latency from scan_clk rise, then an ignored rise during blanking
    latency_tick();
    double_rise();

    // All-zero digits with one decimal point
    do_reset();
    digits = 32'h00000000;
    dp     = 8'h04;
    for (int i = 0; i < 8; i++) tick();

    // Mid-frame data change is held off until the next snapshot
    do_reset();
    digits = 32'h11111111;
    dp     = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    digits = 32'h22222222;
    for (int i = 0; i < 13; i++) tick();

    // Asynchronous reset while a digit is driven
    check_eq("pre_rst_driven", (seg_com != 8'hFF), 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_com", seg_com, 8'hFF);
    check_eq("async_rst_data", seg_data, 8'h00);
    check_eq("async_rst_frame", frame_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_idx = ND - 1;
    exp_q.delete();
    fs_cnt = 0;
    digits = 32'hABCDEF09;
    dp     = 8'h01;
    tick();
    check_eq("post_rst_digit0", seg_data, 8'hEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
